// File: rtl/vga_pkg.sv
// XGA raster timing constants and counter typedef, shared by the timing generator
// and by drawing stages that need the screen geometry.
package vga_pkg;

    localparam int CNT_W = 11;

    typedef logic [CNT_W-1:0] count_t;

    localparam int XGA_H_ACTIVE     = 1024;
    localparam int XGA_H_SYNC_START = 1048;
    localparam int XGA_H_SYNC_END   = 1184;
    localparam int XGA_H_TOTAL      = 1344;
    localparam int XGA_V_ACTIVE     = 768;
    localparam int XGA_V_SYNC_START = 771;
    localparam int XGA_V_SYNC_END   = 777;
    localparam int XGA_V_TOTAL      = 806;

    // Active < sync start < sync end <= total, and total must fit the counter.
    function automatic bit timing_legal(int active, int sync_start, int sync_end, int total);
        return (active < sync_start) && (sync_start < sync_end) &&
               (sync_end <= total) && (total <= (1 << CNT_W));
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Pixel-stream bus: raster position plus sync/blanking flags, all coincident.
interface vga_timing_if;
    import vga_pkg::*;

    count_t hcount;
    count_t vcount;
    logic   hsync;
    logic   hblnk;
    logic   vsync;
    logic   vblnk;

    modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk);
    modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk);
endinterface

// File: rtl/vga_timing_wrap_counter.sv
// Modulo-N counter with enable; exposes the next-state value so callers can
// register decodes that line up with the counter itself.
module wrap_counter #(
    parameter int WIDTH   = 11,
    parameter int MODULUS = 1344
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] value_next_o,
    output logic             tc_o
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    assign tc_o = en_i && (value_q == LAST);

    always_comb begin
        value_d = value_q;
        if (tc_o) begin
            value_d = '0;
        end else if (en_i) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o      = value_q;
    assign value_next_o = value_d;

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator; head of the pixel-stream pipeline.
// Flags are decoded from next-state counts so they are coincident with hcount/vcount.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = XGA_H_ACTIVE,
    parameter int H_SYNC_START = XGA_H_SYNC_START,
    parameter int H_SYNC_END   = XGA_H_SYNC_END,
    parameter int H_TOTAL      = XGA_H_TOTAL,
    parameter int V_ACTIVE     = XGA_V_ACTIVE,
    parameter int V_SYNC_START = XGA_V_SYNC_START,
    parameter int V_SYNC_END   = XGA_V_SYNC_END,
    parameter int V_TOTAL      = XGA_V_TOTAL
) (
    input  logic         pclk,
    input  logic         rst,
    vga_timing_if.master vga,
    output logic         frame_start
);
    if (!timing_legal(H_ACTIVE, H_SYNC_START, H_SYNC_END, H_TOTAL) ||
        !timing_legal(V_ACTIVE, V_SYNC_START, V_SYNC_END, V_TOTAL)) begin : g_bad_timing
        $error("vga_timing: illegal raster timing parameters");
    end

    count_t h_q, h_d, v_q, v_d;
    logic   h_tc, v_tc;

    wrap_counter #(.WIDTH(CNT_W), .MODULUS(H_TOTAL)) u_hcnt (
        .clk          (pclk),
        .rst          (rst),
        .en_i         (1'b1),
        .value_o      (h_q),
        .value_next_o (h_d),
        .tc_o         (h_tc)
    );

    // Vertical advances only on the line wrap, so vsync/vblnk edges sit at hcount = 0.
    wrap_counter #(.WIDTH(CNT_W), .MODULUS(V_TOTAL)) u_vcnt (
        .clk          (pclk),
        .rst          (rst),
        .en_i         (h_tc),
        .value_o      (v_q),
        .value_next_o (v_d),
        .tc_o         (v_tc)
    );

    logic hsync_q, hsync_d, hblnk_q, hblnk_d;
    logic vsync_q, vsync_d, vblnk_q, vblnk_d;
    logic fs_q, fs_d;

    always_comb begin
        hsync_d = (int'(h_d) >= H_SYNC_START) && (int'(h_d) < H_SYNC_END);
        hblnk_d = (int'(h_d) >= H_ACTIVE);
        vsync_d = (int'(v_d) >= V_SYNC_START) && (int'(v_d) < V_SYNC_END);
        vblnk_d = (int'(v_d) >= V_ACTIVE);
        // Only a genuine frame wrap strobes; the post-reset (0,0) does not.
        fs_d    = h_tc && v_tc;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hsync_q <= 1'b0;
            hblnk_q <= 1'b0;
            vsync_q <= 1'b0;
            vblnk_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            hblnk_q <= hblnk_d;
            vsync_q <= vsync_d;
            vblnk_q <= vblnk_d;
            fs_q    <= fs_d;
        end
    end

    assign vga.hcount  = h_q;
    assign vga.vcount  = v_q;
    assign vga.hsync   = hsync_q;
    assign vga.hblnk   = hblnk_q;
    assign vga.vsync   = vsync_q;
    assign vga.vblnk   = vblnk_q;
    assign frame_start = fs_q;

endmodule
